// File: rtl/awg_pkg.sv
// Shared constants and types for the status-report path.
package awg_pkg;

  localparam int unsigned FRAME_LEN = 18;

  localparam logic [7:0] ASCII_S  = 8'h53;
  localparam logic [7:0] ASCII_F  = 8'h46;
  localparam logic [7:0] ASCII_A  = 8'h41;
  localparam logic [7:0] ASCII_P  = 8'h50;
  localparam logic [7:0] ASCII_SP = 8'h20;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_0  = 8'h30;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONV_F,
    ST_CONV_P,
    ST_SEND,
    ST_ACK,
    ST_WAIT
  } rpt_state_e;

  function automatic logic [7:0] ascii_digit(input logic [3:0] d);
    return ASCII_0 + {4'h0, d};
  endfunction

endpackage

// File: rtl/state_report_if.sv
// Byte-write handshake towards the UART transmitter.
interface state_report_if;
  logic [7:0] tx_data;
  logic       tx_wr;
  logic       tx_busy;

  modport master (output tx_data, output tx_wr, input tx_busy);
  modport slave  (input tx_data, input tx_wr, output tx_busy);
endinterface

// File: rtl/state_report_bcd.sv
// Sequential double-dabble: 12-bit binary to 4-digit BCD in 12 shift cycles.
module bin2bcd_12 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [11:0] bin,
  output logic [15:0] bcd,
  output logic        done
);

  logic [11:0] sh_q, sh_d;
  logic [15:0] acc_q, acc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] adj;

  // Add 3 to every BCD digit that is 5 or more before the next shift.
  always_comb begin
    adj = acc_q;
    for (int unsigned i = 0; i < 4; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
  end

  // Load on start when idle, then shift once per cycle; done pulses after the last shift.
  always_comb begin
    sh_d   = sh_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (!busy_q) begin
      if (start) begin
        sh_d   = bin;
        acc_d  = '0;
        cnt_d  = 4'd12;
        busy_d = 1'b1;
      end
    end else begin
      {acc_d, sh_d} = {adj, sh_q} << 1;
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  // Converter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q   <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      sh_q   <= sh_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign bcd  = acc_q;
  assign done = done_q;

endmodule

// File: rtl/state_report.sv
// Snapshots generator settings and streams them to the UART as "S s F ffff A a P ppp\r\n".
module state_report
  import awg_pkg::*;
#(
  parameter int unsigned REPORT_PERIOD = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  report_req,
  input  logic [2:0]            state,
  input  logic [11:0]           state_freq,
  input  logic [2:0]            state_amp,
  input  logic [7:0]            state_phase,
  state_report_if.master        tx,
  output logic                  report_busy
);

  rpt_state_e  fsm_q, fsm_d;
  logic [2:0]  snap_state_q, snap_state_d;
  logic [11:0] snap_freq_q, snap_freq_d;
  logic [2:0]  snap_amp_q, snap_amp_d;
  logic [7:0]  snap_phase_q, snap_phase_d;
  logic [15:0] freq_bcd_q, freq_bcd_d;
  logic [11:0] phase_bcd_q, phase_bcd_d;
  logic [4:0]  idx_q, idx_d;
  logic [31:0] cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        start_q, start_d;
  logic        tx_wr_q, tx_wr_d;
  logic [7:0]  tx_data_q, tx_data_d;

  logic        auto_fire, accept, last_byte;
  logic [11:0] bcd_bin;
  logic [15:0] bcd_out;
  logic        bcd_done;
  logic [7:0]  frame_byte;

  assign auto_fire = (REPORT_PERIOD != 0) && (cnt_q == 32'(REPORT_PERIOD - 1));
  assign accept    = (fsm_q == ST_IDLE) && (report_req || auto_fire);
  assign last_byte = (idx_q == 5'(FRAME_LEN - 1));
  // The converter is shared: freq is converted first, then phase.
  assign bcd_bin   = (fsm_q == ST_CONV_P) ? {4'b0, snap_phase_q} : snap_freq_q;

  bin2bcd_12 u_bcd (
    .clk   (clk),
    .rst   (rst),
    .start (start_q),
    .bin   (bcd_bin),
    .bcd   (bcd_out),
    .done  (bcd_done)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fsm_q <= ST_IDLE;
    else     fsm_q <= fsm_d;
  end

  // Next-state logic.
  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      ST_IDLE:   if (accept) fsm_d = ST_CONV_F;
      ST_CONV_F: if (bcd_done) fsm_d = ST_CONV_P;
      ST_CONV_P: if (bcd_done) fsm_d = ST_SEND;
      ST_SEND:   if (!tx.tx_busy) fsm_d = ST_ACK;
      ST_ACK:    fsm_d = ST_WAIT;
      ST_WAIT:   if (!tx.tx_busy) fsm_d = last_byte ? ST_IDLE : ST_SEND;
      default:   fsm_d = ST_IDLE;
    endcase
  end

  // Output and datapath updates per state.
  always_comb begin
    snap_state_d = snap_state_q;
    snap_freq_d  = snap_freq_q;
    snap_amp_d   = snap_amp_q;
    snap_phase_d = snap_phase_q;
    freq_bcd_d   = freq_bcd_q;
    phase_bcd_d  = phase_bcd_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    busy_d       = busy_q;
    tx_data_d    = tx_data_q;
    start_d      = 1'b0;
    tx_wr_d      = 1'b0;
    case (fsm_q)
      ST_IDLE: begin
        if (accept) begin
          snap_state_d = state;
          snap_freq_d  = state_freq;
          snap_amp_d   = state_amp;
          snap_phase_d = state_phase;
          busy_d       = 1'b1;
          cnt_d        = '0;
          start_d      = 1'b1;
        end else if (REPORT_PERIOD != 0) begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_CONV_F: begin
        if (bcd_done) begin
          freq_bcd_d = bcd_out;
          start_d    = 1'b1;
        end
      end
      ST_CONV_P: begin
        if (bcd_done) begin
          phase_bcd_d = bcd_out[11:0];
          idx_d       = '0;
        end
      end
      ST_SEND: begin
        if (!tx.tx_busy) begin
          tx_wr_d   = 1'b1;
          tx_data_d = frame_byte;
        end
      end
      ST_WAIT: begin
        if (!tx.tx_busy) begin
          if (last_byte) busy_d = 1'b0;
          else           idx_d  = idx_q + 5'd1;
        end
      end
      default: ;
    endcase
  end

  // Byte selection for the current frame position.
  always_comb begin
    frame_byte = ASCII_SP;
    case (idx_q)
      5'd0:    frame_byte = ASCII_S;
      5'd1:    frame_byte = ascii_digit({1'b0, snap_state_q});
      5'd3:    frame_byte = ASCII_F;
      5'd4:    frame_byte = ascii_digit(freq_bcd_q[15:12]);
      5'd5:    frame_byte = ascii_digit(freq_bcd_q[11:8]);
      5'd6:    frame_byte = ascii_digit(freq_bcd_q[7:4]);
      5'd7:    frame_byte = ascii_digit(freq_bcd_q[3:0]);
      5'd9:    frame_byte = ASCII_A;
      5'd10:   frame_byte = ascii_digit({1'b0, snap_amp_q});
      5'd12:   frame_byte = ASCII_P;
      5'd13:   frame_byte = ascii_digit(phase_bcd_q[11:8]);
      5'd14:   frame_byte = ascii_digit(phase_bcd_q[7:4]);
      5'd15:   frame_byte = ascii_digit(phase_bcd_q[3:0]);
      5'd16:   frame_byte = ASCII_CR;
      5'd17:   frame_byte = ASCII_LF;
      default: frame_byte = ASCII_SP;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_state_q <= '0;
      snap_freq_q  <= '0;
      snap_amp_q   <= '0;
      snap_phase_q <= '0;
      freq_bcd_q   <= '0;
      phase_bcd_q  <= '0;
      idx_q        <= '0;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      start_q      <= 1'b0;
      tx_wr_q      <= 1'b0;
      tx_data_q    <= '0;
    end else begin
      snap_state_q <= snap_state_d;
      snap_freq_q  <= snap_freq_d;
      snap_amp_q   <= snap_amp_d;
      snap_phase_q <= snap_phase_d;
      freq_bcd_q   <= freq_bcd_d;
      phase_bcd_q  <= phase_bcd_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
      start_q      <= start_d;
      tx_wr_q      <= tx_wr_d;
      tx_data_q    <= tx_data_d;
    end
  end

  assign tx.tx_data  = tx_data_q;
  assign tx.tx_wr    = tx_wr_q;
  assign report_busy = busy_q;

endmodule

// File: doc/state_report.md
Name: state_report

Overview:
- Transmit-side counterpart of the UART command parser.
- Snapshots the current generator settings (state, frequency, amplitude, phase) and formats them as one fixed-length ASCII status line.
- Streams that line byte-by-byte into the UART transmitter through a write-strobe/busy handshake.
- Sits between the setting registers and the UART TX block. Reports are sent on request or periodically.

Parameters:
- REPORT_PERIOD, 0: clocks between automatic reports; 0 disables auto-reporting.
- FRAME_LEN, 18: bytes per status line. Fixed; exported for the bench.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- report_req  in  1  one-cycle pulse requesting a report
- state  in  3  current waveform state, 0..7
- state_freq  in  12  frequency setting, 0..4095
- state_amp  in  3  amplitude setting, 0..7
- state_phase  in  8  phase setting, 0..255
- tx_busy  in  1  UART TX busy; goes high no later than 1 cycle after tx_wr
- tx_data  out  8  byte to transmit; valid while tx_wr is high
- tx_wr  out  1  one-cycle write strobe to UART TX
- report_busy  out  1  high from request accept until the last byte's strobe completes

Behaviour:
- Reset (async, any state): FSM goes to IDLE. tx_wr=0, tx_data=8'h00, report_busy=0, period counter=0, snapshot regs=0.
- Frame format, exactly 18 bytes: "S" s " F" f3 f2 f1 f0 " A" a " P" p2 p1 p0 CR LF.
  - Digits are ASCII '0'+value.
  - state and amp are single digits.
  - freq is 4 decimal digits with leading zeros.
  - phase is 3 decimal digits with leading zeros.
- Trigger is accepted only in IDLE, on either:
  - report_req=1, or
  - the auto counter reaching REPORT_PERIOD-1 (when REPORT_PERIOD≠0).
- On accept, in the same clock edge:
  - snapshot all four inputs;
  - set report_busy=1;
  - clear the auto counter.
  - Later input changes do not affect the frame in flight.
- report_req while report_busy=1 is dropped; there is no queueing.
- Auto counter:
  - counts only in IDLE;
  - holds while busy;
  - if auto expiry and report_req coincide, exactly one frame is sent.
- FSM states:
  - IDLE -> CONV_F on accept.
  - CONV_F: start bin2bcd on freq; wait for done; store 4 BCD digits.
  - -> CONV_P: start bin2bcd on {4'b0,phase}; store the low 3 digits.
  - -> SEND: byte index = 0.
  - SEND: when tx_busy=0, drive tx_data=frame[index] and pulse tx_wr for 1 cycle -> ACK.
  - ACK: one dead cycle, tx_busy ignored -> WAIT.
  - WAIT: stay while tx_busy=1. When tx_busy=0: if index=17, go to IDLE and clear report_busy; else index+1 and go to SEND.
- Handshake rules:
  - tx_wr is never high for 2 consecutive cycles.
  - tx_wr is never asserted while tx_busy=1.
  - tx_data is held stable from the tx_wr cycle until the next byte is loaded.
- Latency: first tx_wr is at most 32 cycles after accept, given tx_busy=0.
- Backpressure: tx_busy held high stalls in SEND/WAIT indefinitely. No timeout, no byte loss.
- Arithmetic: the BCD converter is sequential double-dabble, 12 input bits -> 16-bit BCD, 12 shift cycles. Output is exact for 0..4095.

Decomposition:
- Shared package (awg_pkg) holds:
  - ASCII constants: 'S', 'F', 'A', 'P', space, CR=8'h0D, LF=8'h0A, '0'=8'h30;
  - FRAME_LEN;
  - FSM state encoding localparams.
- Sub-module bin2bcd_12:
  - Ports: clk, rst, start, bin[11:0], bcd[15:0], done.
  - done is a 1-cycle pulse 13 cycles after start.
  - start is ignored while converting.
- Frame byte selection is a combinational mux on index inside state_report.

Test Plan:
- state=3, freq=100, amp=5, phase=50; report_req pulse; tx_busy modelled as a 10-cycle UART -> bytes "S3 F0100 A5 P050\r\n" (18 tx_wr pulses); report_busy falls after LF.
- state=7, freq=4095, amp=7, phase=255 -> "S7 F4095 A7 P255\r\n". Repeat with all zeros -> "S0 F0000 A0 P000\r\n".
- Change inputs mid-frame and pulse report_req at byte 5 -> frame carries the original snapshot; the second request is dropped; exactly 18 strobes total.
- Hold tx_busy=1 for 200 cycles after byte 3 -> no tx_wr during the hold; byte 4 = 'F' is sent after release; no duplicate or skipped bytes.
- Assert rst during byte 9 -> tx_wr=0 and report_busy=0 immediately (async). A fresh report_req afterwards produces a complete, correct frame.
- REPORT_PERIOD=1000, no report_req -> a frame starts every 1000 idle cycles plus frame time. A report_req coinciding with expiry yields one frame only.
